// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters plus a
// return address stack, both trained only by committed control flow from EX.
module branch_predictor #(
  parameter int          ENTRIES     = 64,
  parameter int          RAS_DEPTH   = 8,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_cond,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_call,
  input  logic        ex_ret
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;
  localparam int RASW = $clog2(RAS_DEPTH);
  localparam logic [RASW:0] RAS_FULL = (RASW+1)'(RAS_DEPTH);

  logic            validMem  [ENTRIES];
  logic [1:0]      ctrMem    [ENTRIES];
  logic [TAGW-1:0] tagMem    [ENTRIES];
  logic [31:0]     targetMem [ENTRIES];
  logic            kindMem   [ENTRIES];

  logic [31:0]     rasMem [RAS_DEPTH];
  logic [RASW-1:0] rasPtr;
  logic [RASW-1:0] rasNext;
  logic [RASW:0]   rasCount;

  logic [IDX-1:0]  ifIdx;
  logic [IDX-1:0]  exIdx;
  logic [TAGW-1:0] ifTag;
  logic [TAGW-1:0] exTag;
  logic            btbHit;
  logic            exHit;
  logic            exRedirect;
  logic            isReturn;
  logic            doPush;
  logic            doPop;
  logic            doReplace;
  logic [31:0]     linkAddr;
  logic            unusedInstBits;

  assign ifIdx = if_pc[IDX+1:2];
  assign ifTag = if_pc[31:IDX+2];
  assign exIdx = ex_pc[IDX+1:2];
  assign exTag = ex_pc[31:IDX+2];

  // Unwritten entries carry X tags; the valid bit gates them out first.
  assign btbHit     = validMem[ifIdx] && (tagMem[ifIdx] == ifTag);
  assign exHit      = validMem[exIdx] && (tagMem[exIdx] == exTag);
  assign exRedirect = !ex_cond || ex_taken;

  assign isReturn = (if_inst[31:26] == 6'd0) && (if_inst[25:21] == 5'd31) &&
                    (if_inst[5:0] == 6'h08);
  assign unusedInstBits = ^if_inst[20:6];

  assign linkAddr  = ex_pc + LINK_OFFSET;
  assign rasNext   = rasPtr + 1'b1;
  // Call+return together overwrites the top, except on an empty stack.
  assign doPush    = ex_valid && ex_call && (!ex_ret || rasCount == '0);
  assign doReplace = ex_valid && ex_call && ex_ret && (rasCount != '0);
  assign doPop     = ex_valid && ex_ret && !ex_call && (rasCount != '0);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = if_pc + 32'd4;
    if (isReturn && rasCount != '0) begin
      pred_taken  = 1'b1;
      pred_target = rasMem[rasPtr];
    end else if (btbHit && (kindMem[ifIdx] || ctrMem[ifIdx][1])) begin
      pred_taken  = 1'b1;
      pred_target = targetMem[ifIdx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validMem[i] <= 1'b0;
        ctrMem[i]   <= 2'd0;
      end
    end else if (ex_valid) begin
      if (exHit) begin
        if (!ex_cond)
          ctrMem[exIdx] <= 2'd3;
        else if (ex_taken && ctrMem[exIdx] != 2'd3)
          ctrMem[exIdx] <= ctrMem[exIdx] + 2'd1;
        else if (!ex_taken && ctrMem[exIdx] != 2'd0)
          ctrMem[exIdx] <= ctrMem[exIdx] - 2'd1;
      end else if (exRedirect) begin
        validMem[exIdx] <= 1'b1;
        ctrMem[exIdx]   <= ex_cond ? 2'd2 : 2'd3;
      end
    end
  end

  // Payload fields never need clearing, so they live in reset-free storage.
  always_ff @(posedge clk) begin
    if (ex_valid && exRedirect) begin
      targetMem[exIdx] <= ex_target;
      if (!exHit) begin
        tagMem[exIdx]  <= exTag;
        kindMem[exIdx] <= !ex_cond;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rasPtr   <= '0;
      rasCount <= '0;
    end else if (doPush) begin
      rasPtr <= rasNext;
      if (rasCount != RAS_FULL)
        rasCount <= rasCount + 1'b1;
    end else if (doPop) begin
      rasPtr   <= rasPtr - 1'b1;
      rasCount <= rasCount - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush)
      rasMem[rasNext] <= linkAddr;
    else if (doReplace)
      rasMem[rasPtr] <= linkAddr;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: BTB training, aliasing,
// RAS push/pop/overflow, same-cycle update visibility and async reset.
module tb_branch_predictor;

  localparam logic [31:0] JR_RA = 32'h03E0_0008;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] PC_J  = 32'h0050_0000;

  typedef struct {
    string       tag;
    logic        taken;
    logic [31:0] target;
  } expT;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_cond;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_call;
  logic        ex_ret;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;

  branch_predictor #(.ENTRIES(64), .RAS_DEPTH(8), .LINK_OFFSET(32'd4)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_inst(if_inst),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_cond(ex_cond),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_call(ex_call), .ex_ret(ex_ret)
  );

  always #5 clk = ~clk;

  task automatic expectPred(input string tag, input logic taken, input logic [31:0] target);
    sb.push_back('{tag, taken, target});
  endtask

  task automatic checkOutput();
    expT e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: output sampled with nothing expected");
      return;
    end
    e = sb.pop_front();
    assert ({pred_taken, pred_target} === {e.taken, e.target}) else begin
      errors++;
      $error("[TB] FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
             e.tag, pred_taken, pred_target, e.taken, e.target);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                               input logic expTaken, input logic [31:0] expTarget);
    @(negedge clk);
    if_pc   = pc;
    if_inst = inst;
    expectPred(tag, expTaken, expTarget);
    #2;
    checkOutput();
  endtask

  task automatic exUpdate(input logic [31:0] pc, input logic cond, input logic taken,
                          input logic [31:0] target, input logic call, input logic ret);
    @(negedge clk);
    ex_pc     = pc;
    ex_cond   = cond;
    ex_taken  = taken;
    ex_target = target;
    ex_call   = call;
    ex_ret    = ret;
    ex_valid  = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    ex_call  = 1'b0;
    ex_ret   = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    ex_valid = 1'b0; ex_pc = '0; ex_cond = 1'b0; ex_taken = 1'b0;
    ex_target = '0; ex_call = 1'b0; ex_ret = 1'b0;
    if_pc = 32'h0040_0000; if_inst = NOP;
    expectPred("in_reset", 1'b0, 32'h0040_0004);
    #2;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("after_reset", 32'h0040_0000, NOP, 1'b0, 32'h0040_0004);
    applyStimulus("pc_wrap", 32'hFFFF_FFFC, NOP, 1'b0, 32'h0000_0000);

    // Counter training on a conditional branch
    exUpdate(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    applyStimulus("alloc_taken", 32'h0040_0010, NOP, 1'b1, 32'h0040_0040);
    exUpdate(32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("ctr1_nt", 32'h0040_0010, NOP, 1'b0, 32'h0040_0014);
    exUpdate(32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("ctr0_nt", 32'h0040_0010, NOP, 1'b0, 32'h0040_0014);
    exUpdate(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    applyStimulus("ctr1_t", 32'h0040_0010, NOP, 1'b0, 32'h0040_0014);
    exUpdate(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    applyStimulus("ctr2_t", 32'h0040_0010, NOP, 1'b1, 32'h0040_0040);
    for (int i = 0; i < 5; i++)
      exUpdate(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    applyStimulus("ctr_sat5", 32'h0040_0010, NOP, 1'b1, 32'h0040_0040);
    exUpdate(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b0);
    applyStimulus("ctr_sat6", 32'h0040_0010, NOP, 1'b1, 32'h0040_0040);
    exUpdate(32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("ctr3to2", 32'h0040_0010, NOP, 1'b1, 32'h0040_0040);
    exUpdate(32'h0040_0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus("ctr2to1", 32'h0040_0010, NOP, 1'b0, 32'h0040_0014);
    exUpdate(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080, 1'b0, 1'b0);
    applyStimulus("target_update", 32'h0040_0010, NOP, 1'b1, 32'h0040_0080);

    // Aliasing at index 4, and no allocation for a not-taken miss
    exUpdate(32'h0040_0110, 1'b0, 1'b0, 32'h0040_0200, 1'b0, 1'b0);
    applyStimulus("alias_evicted", 32'h0040_0010, NOP, 1'b0, 32'h0040_0014);
    applyStimulus("alias_uncond", 32'h0040_0110, NOP, 1'b1, 32'h0040_0200);
    exUpdate(32'h0040_0300, 1'b1, 1'b0, 32'h0040_0900, 1'b0, 1'b0);
    applyStimulus("nt_no_alloc", 32'h0040_0300, NOP, 1'b0, 32'h0040_0304);

    // Lookup during an update at the same index sees the old target
    @(negedge clk);
    ex_pc = 32'h0040_0110; ex_cond = 1'b0; ex_taken = 1'b0;
    ex_target = 32'h0040_0300; ex_valid = 1'b1;
    if_pc = 32'h0040_0110; if_inst = NOP;
    expectPred("same_cycle_old", 1'b1, 32'h0040_0200);
    #2;
    checkOutput();
    @(negedge clk);
    ex_valid = 1'b0;
    expectPred("next_cycle_new", 1'b1, 32'h0040_0300);
    #2;
    checkOutput();

    // ex_valid low must ignore every other ex input
    @(negedge clk);
    ex_pc = 32'h0040_0110; ex_cond = 1'b0; ex_taken = 1'b1;
    ex_target = 32'h0040_0500; ex_call = 1'b1; ex_ret = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ex_call = 1'b0;
    applyStimulus("exvalid0_btb", 32'h0040_0110, NOP, 1'b1, 32'h0040_0300);
    applyStimulus("ras_empty", PC_J, JR_RA, 1'b0, PC_J + 32'd4);

    // Basic call/return
    exUpdate(32'h0000_1000, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0);
    exUpdate(32'h0000_2000, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0);
    applyStimulus("ras_top2", PC_J, JR_RA, 1'b1, 32'h0000_2004);
    exUpdate(32'h0060_0000, 1'b0, 1'b1, 32'h0000_2004, 1'b0, 1'b1);
    applyStimulus("ras_top1", PC_J, JR_RA, 1'b1, 32'h0000_1004);
    exUpdate(32'h0060_0000, 1'b0, 1'b1, 32'h0000_1004, 1'b0, 1'b1);
    applyStimulus("ras_drained", PC_J, JR_RA, 1'b0, PC_J + 32'd4);

    // Overflow: nine pushes into eight slots drops the oldest
    for (int k = 1; k <= 9; k++)
      exUpdate(32'(k) * 32'h100, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0);
    applyStimulus("ras_full_top", PC_J, JR_RA, 1'b1, 32'h0000_0904);
    for (int i = 0; i < 8; i++) begin
      exUpdate(32'h0060_0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      if (i < 7)
        applyStimulus("ras_pop_seq", PC_J, JR_RA, 1'b1, 32'h0000_0904 - 32'(i + 1) * 32'h100);
      else
        applyStimulus("ras_pop_last", PC_J, JR_RA, 1'b0, PC_J + 32'd4);
    end
    exUpdate(32'h0060_0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus("ras_pop_empty", PC_J, JR_RA, 1'b0, PC_J + 32'd4);

    // Simultaneous call and return
    exUpdate(32'h0000_0A00, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b0);
    applyStimulus("ras_after_underflow", PC_J, JR_RA, 1'b1, 32'h0000_0A04);
    exUpdate(32'h0000_0B00, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    applyStimulus("ras_replace", PC_J, JR_RA, 1'b1, 32'h0000_0B04);
    exUpdate(32'h0060_0000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus("ras_replace_count", PC_J, JR_RA, 1'b0, PC_J + 32'd4);
    exUpdate(32'h0000_0C00, 1'b0, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    applyStimulus("ras_both_empty", PC_J, JR_RA, 1'b1, 32'h0000_0C04);

    // Async reset in the middle of an update
    @(negedge clk);
    ex_pc = 32'h0040_0110; ex_cond = 1'b0; ex_taken = 1'b1;
    ex_target = 32'h0040_0600; ex_call = 1'b1; ex_valid = 1'b1;
    if_pc = 32'h0040_0110; if_inst = NOP;
    #1;
    reset = 1'b1;
    expectPred("reset_btb", 1'b0, 32'h0040_0114);
    #1;
    checkOutput();
    if_pc = PC_J; if_inst = JR_RA;
    expectPred("reset_ras", 1'b0, PC_J + 32'd4);
    #1;
    checkOutput();
    @(negedge clk);
    ex_valid = 1'b0; ex_call = 1'b0;
    reset = 1'b0;
    applyStimulus("post_reset_btb", 32'h0040_0110, NOP, 1'b0, 32'h0040_0114);
    applyStimulus("post_reset_ras", PC_J, JR_RA, 1'b0, PC_J + 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
